intr_ctrl: RTL and testbench
============================

# intr_ctrl

Machine-mode interrupt controller for the RV32I core. It synchronises the external, timer and software interrupt sources and drives the write port of the mip register. It selects the highest-priority pending, enabled interrupt and sequences trap entry with the pipeline through a request/acknowledge handshake. It sits between the interrupt pins, the CSR file (mip/mie/mstatus/mtvec) and the core's fetch/flush logic.

## Interface
- No parameters.
- clk  in  1  core clock; the block uses one clock.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- ext_irq  in  1  external interrupt level; asynchronous to clk.
- timer_irq  in  1  timer interrupt level; asynchronous to clk.
- csr_wr_mip  in  1  CSR instruction writes mip this cycle.
- csr_wdata  in  32  CSR write data. Only bit 3 (MSIP) is honoured.
- mip  in  32  current mip register value.
- mie  in  32  current mie register value.
- mstatus_mie  in  1  global machine interrupt enable.
- mtvec  in  32  trap vector. Bits [1:0]: 0 = direct, 1 = vectored.
- intr_ack  in  1  pipeline drained; epc_in is valid.
- epc_in  in  32  PC of the oldest unretired instruction.
- mip_in  out  32  next mip value.
- wr_mip  out  1  mip write strobe.
- intr_req  out  1  request the pipeline to stop and drain.
- trap_en  out  1  one-cycle trap commit strobe.
- mcause_out  out  32  cause value, valid with trap_en.
- mepc_out  out  32  saved PC, valid with trap_en.
- trap_pc  out  32  redirect target, valid with trap_en.
- clr_mstatus_mie  out  1  clear mstatus.MIE and save it to MPIE; pulses with trap_en.

## Operation
- **Synchronisers.** ext_irq and timer_irq each pass through a 2-flop synchroniser, giving meip_s and mtip_s.
- **mip drive.**
  - msip_r is set from csr_wdata[3] when csr_wr_mip = 1; otherwise it holds.
  - mip_in = {20'b0, meip_s, 3'b0, mtip_s, 3'b0, msip_next, 3'b0}.
  - wr_mip = 1 when csr_wr_mip = 1 or when {meip_s, mtip_s} differs from {mip[11], mip[7]}.
  - All S- and U-mode bits are driven 0.
- **Pending set.** pend = mip & mie & {32{mstatus_mie}}, restricted to bits 11, 7 and 3.
- **Priority.** MEI (code 11) > MSI (code 3) > MTI (code 7).
- **State machine** (states IDLE, REQ, TRAP):
  - IDLE: when pend ≠ 0, latch the winning code into cause_r and go to REQ.
  - REQ: intr_req = 1.
    - intr_ack = 1 → latch epc_in, go to TRAP.
    - Otherwise, if pend bit cause_r has dropped → IDLE, intr_req drops next cycle.
    - Ack arriving in the same cycle as the drop → the ack wins and the trap proceeds.
    - A higher-priority source arriving while in REQ does not change cause_r.
  - TRAP: trap_en = 1 and clr_mstatus_mie = 1 for one cycle, then IDLE.
- **Trap outputs.**
  - mcause_out = {1'b1, 27'b0, cause_r}.
  - mepc_out = latched epc with bits [1:0] forced to 0.
  - trap_pc = {mtvec[31:2], 2'b00}; in vectored mode, add cause_r × 4.
  - All arithmetic is 32-bit and wraps modulo 2^32.
  - mtvec[1:0] = 2 or 3 is treated as direct.
- **Reset.** All outputs 0, state IDLE, msip_r = 0, synchronisers 0. Reset asserted mid-REQ or mid-TRAP aborts with no trap_en.

## Timing
- Pin to mip: ext_irq/timer_irq rising → wr_mip asserted 2 cycles later (synchroniser), so the mip register updates 3 cycles after the pin.
- mip to request: mip updated → pend visible the same cycle → REQ entered next edge → intr_req high 1 cycle after mip updates.
- Handshake: intr_ack sampled at a REQ edge → trap_en high in the following cycle for exactly 1 cycle. Minimum request-to-trap latency is 2 cycles.
- Re-entry: no new REQ in the TRAP cycle. IDLE re-evaluates pend using the updated mstatus_mie (already 0 after the clear), so no back-to-back trap.
- intr_ack outside REQ is ignored.
- CSR write and a pin change in the same cycle → a single wr_mip carrying both updates.

## Structure
- **Shared package (cpu package):**
  - cause codes MEI = 11, MSI = 3, MTI = 7.
  - mip/mie bit indices.
  - mtvec mode encodings.
  - FSM state enum.
- **Sub-module:** sync2 (2-flop synchroniser, reset to 0), instantiated twice.
- Priority select and trap_pc computation stay inline.

## Test plan
- **Reset:** assert rst_n = 0 mid-REQ → intr_req, trap_en, wr_mip all 0; FSM returns to IDLE.
- **External interrupt, direct mode:**
  - Setup: ext_irq = 1, mie[11] = 1, mstatus_mie = 1, mtvec = 0x8000_0000.
  - Stimulus: ack 3 cycles after intr_req, epc_in = 0x0000_0106.
  - Required: wr_mip with mip_in[11] = 1 at +2; trap_en with mcause = 0x8000_000B, mepc = 0x0000_0104, trap_pc = 0x8000_0000.
- **Vectored timer:** mtvec = 0x0000_1001, timer_irq only → trap_pc = 0x0000_101C, mcause = 0x8000_0007.
- **Priority:** ext, timer and software (csr_wdata = 0x8) all pending in the same cycle → mcause code 11. Clearing ext then gives code 3 before code 7.
- **Withdrawal:** timer_irq drops while in REQ with no ack → IDLE, no trap_en. Repeat with ack in the same cycle as the drop → trap_en with cause 7.
- **Masking:** mstatus_mie = 0 with ext pending → wr_mip occurs but intr_req stays 0. Setting mstatus_mie = 1 → intr_req 1 cycle later.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intr_ctrl_pkg
// Description : Shared constants, state encoding and the priority helper
//               used by the machine-mode interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package intr_ctrl_pkg;

  // mcause exception codes for the three machine-mode interrupt sources
  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  // Bit positions inside mip / mie
  localparam int MIP_MSIP_BIT = 3;
  localparam int MIP_MTIP_BIT = 7;
  localparam int MIP_MEIP_BIT = 11;

  // Only the three machine-mode interrupt bits take part in arbitration
  localparam logic [31:0] PEND_MASK = 32'h0000_0888;

  // mtvec mode field encodings (anything else behaves as direct)
  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  // Trap-entry sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  // Fixed priority MEI > MSI > MTI; returns 0 when nothing is pending
  function automatic logic [3:0] pick_cause(input logic [31:0] pend);
    if (pend[MIP_MEIP_BIT]) begin
      return CAUSE_MEI;
    end else if (pend[MIP_MSIP_BIT]) begin
      return CAUSE_MSI;
    end else if (pend[MIP_MTIP_BIT]) begin
      return CAUSE_MTI;
    end
    return 4'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/intr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : intr_ctrl_if
// Description : Bundles the pin, CSR and pipeline-handshake signals of the
//               interrupt controller. master = controller, slave = core side.
// Revision    : 1.0 - initial release
// ============================================================================
interface intr_ctrl_if;

  // Interrupt pins and CSR state
  logic        ext_irq;
  logic        timer_irq;
  logic        csr_wr_mip;
  logic [31:0] csr_wdata;
  logic [31:0] mip;
  logic [31:0] mie;
  logic        mstatus_mie;
  logic [31:0] mtvec;

  // Pipeline handshake
  logic        intr_ack;
  logic [31:0] epc_in;

  // Controller outputs
  logic [31:0] mip_in;
  logic        wr_mip;
  logic        intr_req;
  logic        trap_en;
  logic [31:0] mcause_out;
  logic [31:0] mepc_out;
  logic [31:0] trap_pc;
  logic        clr_mstatus_mie;

  modport master (
    input  ext_irq, timer_irq, csr_wr_mip, csr_wdata, mip, mie,
           mstatus_mie, mtvec, intr_ack, epc_in,
    output mip_in, wr_mip, intr_req, trap_en, mcause_out, mepc_out,
           trap_pc, clr_mstatus_mie
  );

  modport slave (
    output ext_irq, timer_irq, csr_wr_mip, csr_wdata, mip, mie,
           mstatus_mie, mtvec, intr_ack, epc_in,
    input  mip_in, wr_mip, intr_req, trap_en, mcause_out, mepc_out,
           trap_pc, clr_mstatus_mie
  );

endinterface
`default_nettype wire

// File: rtl/intr_ctrl_sync2.sv
`default_nettype none
// ============================================================================
// Module      : intr_ctrl_sync2
// Description : Two-flop level synchroniser, clears to 0 on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module intr_ctrl_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the asynchronous level through two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : intr_ctrl
// Description : Machine-mode interrupt controller. Synchronises the external
//               and timer pins, drives the mip write port, arbitrates the
//               pending/enabled sources and sequences trap entry with the
//               pipeline through an intr_req / intr_ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module intr_ctrl
  import intr_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  intr_ctrl_if.master  bus
);

  logic        meip_s;
  logic        mtip_s;

  logic        msip_q, msip_d;
  state_e      state_q, state_d;
  logic [3:0]  cause_q, cause_d;
  logic [29:0] epc_q, epc_d;

  logic [31:0] pend;
  logic [3:0]  win_cause;
  logic [31:0] trap_base;

  logic [31:0] mip_in_w;
  logic        wr_mip_w;
  logic        intr_req_w;
  logic        trap_en_w;
  logic        clr_mie_w;
  logic [31:0] mcause_w;
  logic [31:0] mepc_w;
  logic [31:0] trap_pc_w;

  // Bits the controller deliberately ignores
  logic        unused_bits;
  assign unused_bits = ^{bus.csr_wdata[31:4], bus.csr_wdata[2:0], bus.epc_in[1:0]};

  intr_ctrl_sync2 u_sync_ext (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.ext_irq),
    .q     (meip_s)
  );

  intr_ctrl_sync2 u_sync_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.timer_irq),
    .q     (mtip_s)
  );

  // mip write port: software bit from CSR writes, pin bits from synchronisers
  always_comb begin
    msip_d   = bus.csr_wr_mip ? bus.csr_wdata[MIP_MSIP_BIT] : msip_q;
    mip_in_w = {20'b0, meip_s, 3'b0, mtip_s, 3'b0, msip_d, 3'b0};
    wr_mip_w = bus.csr_wr_mip
             | (meip_s != bus.mip[MIP_MEIP_BIT])
             | (mtip_s != bus.mip[MIP_MTIP_BIT]);
  end

  // Pending/enabled sources gated by the global enable, then arbitrated
  always_comb begin
    pend      = bus.mip & bus.mie & {32{bus.mstatus_mie}} & PEND_MASK;
    win_cause = pick_cause(pend);
  end

  // State and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      msip_q  <= 1'b0;
      cause_q <= 4'd0;
      epc_q   <= 30'd0;
    end else begin
      state_q <= state_d;
      msip_q  <= msip_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  // Next-state: cause is frozen once a request is raised; ack beats a drop
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    case (state_q)
      ST_IDLE: begin
        if (pend != 32'd0) begin
          cause_d = win_cause;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.intr_ack) begin
          epc_d   = bus.epc_in[31:2];
          state_d = ST_TRAP;
        end else if (!pend[cause_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_TRAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: trap fields are only driven during the commit cycle
  always_comb begin
    intr_req_w = 1'b0;
    trap_en_w  = 1'b0;
    clr_mie_w  = 1'b0;
    mcause_w   = 32'd0;
    mepc_w     = 32'd0;
    trap_pc_w  = 32'd0;
    trap_base  = {bus.mtvec[31:2], 2'b00};
    case (state_q)
      ST_REQ: begin
        intr_req_w = 1'b1;
      end
      ST_TRAP: begin
        trap_en_w = 1'b1;
        clr_mie_w = 1'b1;
        mcause_w  = {1'b1, 27'b0, cause_q};
        mepc_w    = {epc_q, 2'b00};
        if (bus.mtvec[1:0] == MTVEC_VECTORED) begin
          trap_pc_w = trap_base + {26'b0, cause_q, 2'b00};
        end else begin
          trap_pc_w = trap_base;
        end
      end
      default: begin
        intr_req_w = 1'b0;
      end
    endcase
  end

  assign bus.mip_in          = mip_in_w;
  assign bus.wr_mip          = wr_mip_w;
  assign bus.intr_req        = intr_req_w;
  assign bus.trap_en         = trap_en_w;
  assign bus.clr_mstatus_mie = clr_mie_w;
  assign bus.mcause_out      = mcause_w;
  assign bus.mepc_out        = mepc_w;
  assign bus.trap_pc         = trap_pc_w;

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_intr_ctrl
// Description : Self-checking bench for intr_ctrl. A behavioural model of the
//               pins, CSR file and trap sequence predicts every output each
//               cycle; directed scenarios pin the model with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intr_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  intr_ctrl_if bus ();

  intr_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: pin history (value seen one and two edges ago), software bit,
  // request/trap flags and captured trap data
  bit          ext_d1, ext_d2, tim_d1, tim_d2;
  bit          m_msip, m_req, m_trap;
  int          m_cause;
  logic [31:0] m_epc;

  // Expectations from the most recent compare
  bit          e_msn, e_wr, e_clr;
  logic [31:0] e_mip_in, e_pend;

  // DUT snapshot from the most recent compare
  logic        d_req, d_trap, d_wr;
  logic [31:0] d_mip_in, d_mcause, d_mepc, d_pc;
  bit          saw_trap, saw_wr, saw_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [31:0] p);
    int order [3];
    order = '{11, 3, 7};
    for (int i = 0; i < 3; i++) begin
      if (p[order[i]]) return order[i];
    end
    return 0;
  endfunction

  task automatic model_reset();
    ext_d1 = 0; ext_d2 = 0; tim_d1 = 0; tim_d2 = 0;
    m_msip = 0; m_req = 0; m_trap = 0; m_cause = 0; m_epc = '0;
  endtask

  task automatic compare();
    bit meip, mtip;
    logic [31:0] exp_pc;
    meip     = ext_d2;
    mtip     = tim_d2;
    e_msn    = bus.csr_wr_mip ? bus.csr_wdata[3] : m_msip;
    e_mip_in = (32'(meip) << 11) | (32'(mtip) << 7) | (32'(e_msn) << 3);
    e_wr     = bus.csr_wr_mip || (meip != bus.mip[11]) || (mtip != bus.mip[7]);
    e_pend   = bus.mstatus_mie ? (bus.mip & bus.mie & 32'h0000_0888) : 32'd0;
    e_clr    = m_trap;
    exp_pc   = bus.mtvec & ~32'h3;
    if (bus.mtvec[1:0] == 2'd1) exp_pc = exp_pc + 32'(m_cause * 4);

    d_req    = bus.intr_req;
    d_trap   = bus.trap_en;
    d_wr     = bus.wr_mip;
    d_mip_in = bus.mip_in;
    d_mcause = bus.mcause_out;
    d_mepc   = bus.mepc_out;
    d_pc     = bus.trap_pc;

    check("mip_in",   d_mip_in, e_mip_in);
    check("wr_mip",   32'(d_wr), 32'(e_wr));
    check("intr_req", 32'(d_req), 32'(m_req));
    check("trap_en",  32'(d_trap), 32'(m_trap));
    check("clr_mie",  32'(bus.clr_mstatus_mie), 32'(m_trap));
    check("mcause",   d_mcause, m_trap ? (32'h8000_0000 | 32'(m_cause)) : 32'd0);
    check("mepc",     d_mepc, m_trap ? (m_epc & ~32'h3) : 32'd0);
    check("trap_pc",  d_pc, m_trap ? exp_pc : 32'd0);

    if (d_trap === 1'b1) saw_trap = 1;
    if (d_wr === 1'b1)   saw_wr = 1;
    if (d_req === 1'b1)  saw_req = 1;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_trap) begin
      m_trap = 0;
    end else if (m_req) begin
      if (bus.intr_ack) begin
        m_trap = 1;
        m_req  = 0;
        m_epc  = bus.epc_in;
      end else if (!e_pend[m_cause]) begin
        m_req = 0;
      end
    end else if (e_pend != 32'd0) begin
      m_req   = 1;
      m_cause = winner(e_pend);
    end
    m_msip = e_msn;
    ext_d2 = ext_d1; ext_d1 = bus.ext_irq;
    tim_d2 = tim_d1; tim_d1 = bus.timer_irq;
  endtask

  // One cycle: check outputs, clock edge, then the CSR file reacts
  task automatic step();
    #1;
    compare();
    @(posedge clk);
    model_edge();
    #1;
    if (!rst_n) begin
      bus.mip = 32'd0;
    end else begin
      if (e_wr)  bus.mip = e_mip_in;
      if (e_clr) bus.mstatus_mie = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ext_irq = 0; bus.timer_irq = 0; bus.csr_wr_mip = 0; bus.csr_wdata = '0;
    bus.intr_ack = 0; bus.epc_in = '0; bus.mip = '0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (d_req !== 1'b1 && n < max) begin
      step();
      n++;
    end
    check("wait_req", 32'(d_req), 32'd1);
  endtask

  // Ack for one cycle; afterwards the snapshot holds the trap cycle
  task automatic do_ack(input logic [31:0] epc);
    bus.intr_ack = 1'b1;
    bus.epc_in   = epc;
    step();
    bus.intr_ack = 1'b0;
    step();
  endtask

  initial begin
    bus.ext_irq = 0; bus.timer_irq = 0; bus.csr_wr_mip = 0; bus.csr_wdata = '0;
    bus.mip = '0; bus.mie = '0; bus.mstatus_mie = 0; bus.mtvec = '0;
    bus.intr_ack = 0; bus.epc_in = '0;
    model_reset();
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_req", 32'(d_req), 32'd0);
    check("rst_trap", 32'(d_trap), 32'd0);
    check("rst_mip_in", d_mip_in, 32'd0);

    // Reset asserted while requesting aborts the trap
    bus.mie = 32'h888; bus.mstatus_mie = 1; bus.mtvec = '0; bus.timer_irq = 1;
    wait_req(20);
    rst_n = 1'b0; model_reset(); bus.mip = '0; bus.intr_ack = 1;
    step();
    check("midreq_rst_req", 32'(d_req), 32'd0);
    check("midreq_rst_trap", 32'(d_trap), 32'd0);
    check("midreq_rst_wr", 32'(d_wr), 32'd0);
    step();
    check("midreq_rst_trap2", 32'(d_trap), 32'd0);
    bus.intr_ack = 0;

    // External interrupt, direct mode
    do_reset();
    bus.mie = 32'h800; bus.mstatus_mie = 1; bus.mtvec = 32'h8000_0000; bus.ext_irq = 1;
    step();
    step();
    check("ext_wr_early", 32'(d_wr), 32'd0);
    step();
    check("ext_wr_at2", 32'(d_wr), 32'd1);
    check("ext_mip_in11", 32'(d_mip_in[11]), 32'd1);
    wait_req(10);
    step();
    step();
    do_ack(32'h0000_0106);
    check("ext_trap", 32'(d_trap), 32'd1);
    check("ext_mcause", d_mcause, 32'h8000_000B);
    check("ext_mepc", d_mepc, 32'h0000_0104);
    check("ext_pc", d_pc, 32'h8000_0000);
    step();
    check("ext_trap_1cyc", 32'(d_trap), 32'd0);

    // Vectored timer
    do_reset();
    bus.mie = 32'h888; bus.mstatus_mie = 1; bus.mtvec = 32'h0000_1001; bus.timer_irq = 1;
    wait_req(10);
    do_ack(32'h0000_2000);
    check("vec_mcause", d_mcause, 32'h8000_0007);
    check("vec_pc", d_pc, 32'h0000_101C);

    // Priority: all three pending together, then peel them off
    do_reset();
    bus.mie = 32'h888; bus.mstatus_mie = 1; bus.mtvec = '0;
    bus.ext_irq = 1; bus.timer_irq = 1;
    step();
    step();
    bus.csr_wr_mip = 1; bus.csr_wdata = 32'h8;
    step();
    bus.csr_wr_mip = 0;
    wait_req(10);
    do_ack(32'h100);
    check("prio_mei", d_mcause, 32'h8000_000B);
    bus.ext_irq = 0;
    for (int i = 0; i < 5; i++) step();
    check("prio_no_reentry", 32'(saw_req && d_req), 32'd0);
    bus.mstatus_mie = 1;
    wait_req(10);
    do_ack(32'h200);
    check("prio_msi", d_mcause, 32'h8000_0003);
    bus.csr_wr_mip = 1; bus.csr_wdata = 32'h0;
    step();
    bus.csr_wr_mip = 0;
    for (int i = 0; i < 4; i++) step();
    bus.mstatus_mie = 1;
    wait_req(10);
    do_ack(32'h300);
    check("prio_mti", d_mcause, 32'h8000_0007);

    // Withdrawal without ack
    do_reset();
    bus.mie = 32'h888; bus.mstatus_mie = 1; bus.timer_irq = 1;
    wait_req(10);
    bus.timer_irq = 0;
    saw_trap = 0;
    for (int i = 0; i < 8; i++) step();
    check("wd_no_trap", 32'(saw_trap), 32'd0);
    check("wd_req_low", 32'(d_req), 32'd0);

    // Withdrawal racing an ack: ack wins
    bus.timer_irq = 1;
    wait_req(10);
    bus.timer_irq = 0;
    for (int n = 0; n < 10 && bus.mip[7]; n++) step();
    check("wd_mip_cleared", 32'(bus.mip[7]), 32'd0);
    do_ack(32'h0000_0abc);
    check("wd_ack_trap", 32'(d_trap), 32'd1);
    check("wd_ack_mcause", d_mcause, 32'h8000_0007);

    // Masking by mstatus.MIE
    do_reset();
    bus.mie = 32'h888; bus.mstatus_mie = 0; bus.ext_irq = 1;
    saw_wr = 0; saw_req = 0;
    for (int i = 0; i < 6; i++) step();
    check("mask_wr_seen", 32'(saw_wr), 32'd1);
    check("mask_no_req", 32'(saw_req), 32'd0);
    bus.mstatus_mie = 1;
    step();
    check("mask_req_same", 32'(d_req), 32'd0);
    step();
    check("mask_req_next", 32'(d_req), 32'd1);

    // Randomised traffic against the model
    do_reset();
    bus.mie = 32'h888; bus.mstatus_mie = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) bus.ext_irq = ~bus.ext_irq;
      if ($urandom_range(0, 15) == 0) bus.timer_irq = ~bus.timer_irq;
      bus.csr_wr_mip = ($urandom_range(0, 7) == 0);
      bus.csr_wdata  = $urandom;
      if ($urandom_range(0, 63) == 0)
        bus.mie = $urandom | (($urandom_range(0, 1) == 1) ? 32'h888 : 32'h0);
      if (!bus.mstatus_mie && $urandom_range(0, 5) == 0) bus.mstatus_mie = 1;
      else if ($urandom_range(0, 99) == 0) bus.mstatus_mie = 0;
      if ($urandom_range(0, 127) == 0) bus.mtvec = $urandom;
      bus.intr_ack = ($urandom_range(0, 2) == 0);
      bus.epc_in   = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        bus.mip = '0;
      end else begin
        rst_n = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
